// File: rtl/sr_pkg.sv
// Shared definitions for the pixel shift-register feed path.
package sr_pkg;

  // Width of one pixel on the RAM data bus and the shift-register bus.
  localparam int PIX_W = 8;

  // Number of shift-register stages that form one pixel window.
  localparam int WIN_DEPTH = 3;

  // Pass sequencing of the feed controller.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } feed_state_t;

  // Counter width able to index n items, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_addr_gen.sv
// Row-major pixel walker: address, column and row counters with wrap and a
// flag marking the final pixel of the image.
module sr_addr_gen
  import sr_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       advance,
  output logic [ADDR_W-1:0]          addr,
  output logic [cnt_w(IMG_H)-1:0]    row,
  output logic                       last
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col;
  logic             col_at_end;

  assign col_at_end = (col == COL_LAST);
  assign last       = col_at_end && (row == ROW_LAST);

  // Counters: reload at pass start, step once per issued read.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (reset) begin
      addr <= ADDR_W'(BASE_ADDR);
      col  <= '0;
      row  <= '0;
    end else if (load) begin
      addr <= ADDR_W'(BASE_ADDR);
      col  <= '0;
      row  <= '0;
    end else if (advance) begin
      // Address wraps modulo 2^ADDR_W without any flag.
      addr <= addr + ADDR_W'(1);
      if (col_at_end) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sr_feed_ctrl.sv
// Producer end of the pixel shift-register chain: walks the image in pixel
// RAM, forwards each returned byte with a load strobe and reports when the
// three-stage window holds three pixels of the same row.
module sr_feed_ctrl
  import sr_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [PIX_W-1:0]  sr_data,
  output logic              sr_en,
  output logic              window_valid,
  output logic              busy,
  output logic              done
);

  localparam int ROW_W  = cnt_w(IMG_H);
  localparam int FILL_W = $clog2(WIN_DEPTH + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN_DEPTH);

  feed_state_t       state;
  feed_state_t       state_nxt;

  logic              load;
  logic              last;
  logic [ROW_W-1:0]  row;

  logic              rd_q;
  logic [ROW_W-1:0]  rd_row_q;

  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic [ROW_W-1:0]  sr_row;

  sr_addr_gen #(
    .ADDR_W    (ADDR_W),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .advance (mem_rd_en),
    .addr    (mem_addr),
    .row     (row),
    .last    (last)
  );

  // Returned RAM byte goes straight onto the shift-register bus.
  assign sr_data = mem_data;
  assign sr_en   = rd_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: one pass per accepted start, final read leads to a one-cycle drain.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: if (!hold && last) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    mem_rd_en = 1'b0;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE:  load = start;
      ST_FETCH: begin
        busy      = 1'b1;
        mem_rd_en = !hold;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Read pipeline: strobe and row tag travel together to the data-return cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q     <= 1'b0;
      rd_row_q <= '0;
    end else begin
      rd_q <= mem_rd_en;
      if (mem_rd_en) rd_row_q <= row;
    end
  end

  // Fill level after the pixel arriving now; a row change restarts the count.
  always_comb begin
    fill_nxt = fill;
    if (rd_q) begin
      if (fill == '0 || rd_row_q != sr_row) fill_nxt = FILL_W'(1);
      else if (fill != FILL_FULL)           fill_nxt = fill + FILL_W'(1);
    end
  end

  // Window tracking: fill level, row of the newest pixel and the valid flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill         <= '0;
      sr_row       <= '0;
      window_valid <= 1'b0;
    end else if (load) begin
      fill         <= '0;
      sr_row       <= '0;
      window_valid <= 1'b0;
    end else if (rd_q) begin
      fill         <= fill_nxt;
      sr_row       <= rd_row_q;
      window_valid <= (fill_nxt == FILL_FULL);
    end else if (state == ST_DONE) begin
      window_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_feed_ctrl.sv
// Self-checking bench for sr_feed_ctrl on a 4x2 image at base address 16.
module tb_sr_feed_ctrl;

  localparam int ADDR_W = 16;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int BASE   = 16;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int WIN    = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              hold;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'h00;
  logic [7:0]        sr_data;
  logic              sr_en;
  logic              window_valid;
  logic              busy;
  logic              done;

  always #5 clock = ~clock;

  sr_feed_ctrl #(
    .ADDR_W    (ADDR_W),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .BASE_ADDR (BASE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .hold         (hold),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .sr_data      (sr_data),
    .sr_en        (sr_en),
    .window_valid (window_valid),
    .busy         (busy),
    .done         (done)
  );

  // Pixel RAM: RAM[16+i] = i, data returned one cycle after the read strobe.
  always @(posedge clock) begin
    if (mem_rd_en) mem_data <= 8'(mem_addr - 16'(BASE));
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Observation logs, written only by the compare process.
  int   cyc         = 0;
  int   n_rd        = 0;
  int   n_sr        = 0;
  int   n_done      = 0;
  int   last_rd_cyc = 0;
  int   done_cyc    = 0;
  logic [7:0] data_log[$];
  bit         wv_log[$];
  int         addr_log[$];

  // Reference model: pass progress as pixel counts, checked every cycle.
  initial begin
    bit m_in_pass, m_done_now, m_pending, m_wv;
    int m_issued, m_pend_idx;
    bit exp_rd, accept, prev_sr;
    m_in_pass = 0; m_done_now = 0; m_pending = 0; m_wv = 0;
    m_issued = 0; m_pend_idx = 0; prev_sr = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_sr_en", sr_en, 0);
        check("rst_window_valid", window_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        m_in_pass = 0; m_done_now = 0; m_pending = 0; m_wv = 0;
        m_issued = 0; m_pend_idx = 0; prev_sr = 0;
      end else begin
        exp_rd = m_in_pass && (m_issued < NPIX) && !hold;
        check("mem_rd_en", mem_rd_en, exp_rd);
        if (exp_rd) check("mem_addr", mem_addr, BASE + m_issued);
        check("sr_en", sr_en, m_pending);
        if (m_pending) check("sr_data", sr_data, m_pend_idx);
        check("window_valid", window_valid, m_wv);
        check("busy", busy, m_in_pass);
        check("done", done, m_done_now);

        if (prev_sr) wv_log.push_back(window_valid);
        if (mem_rd_en) begin
          n_rd++;
          last_rd_cyc = cyc;
          addr_log.push_back(int'(mem_addr));
        end
        if (sr_en) begin
          n_sr++;
          data_log.push_back(sr_data);
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        prev_sr = sr_en;

        // What the next cycle must look like.
        accept = start && !m_in_pass && !m_done_now;
        if (m_pending)       m_wv = ((m_pend_idx % IMG_W) >= WIN - 1);
        else if (m_done_now) m_wv = 0;
        m_done_now = m_pending && (m_pend_idx == NPIX - 1);
        if (m_done_now) m_in_pass = 0;
        m_pending  = exp_rd;
        m_pend_idx = m_issued;
        if (exp_rd) m_issued++;
        if (accept) begin
          m_in_pass = 1;
          m_issued  = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base = n_done;
    int k = 0;
    while (n_done == base && k < 200) begin
      @(negedge clock);
      #1;
      k++;
    end
    check(name, n_done - base, 1);
  endtask

  task automatic wait_reads(input string name, input int base, input int count);
    int k = 0;
    while (n_rd - base < count && k < 200) begin
      @(negedge clock);
      #1;
      k++;
    end
    check(name, n_rd - base, count);
  endtask

  task automatic check_pixels(input string name, input int b_sr, input int b_log);
    check({name, "_sr_count"}, n_sr - b_sr, NPIX);
    if (data_log.size() >= b_log + NPIX) begin
      for (int i = 0; i < NPIX; i++) check({name, "_sr_data"}, data_log[b_log + i], i);
    end
  endtask

  task automatic check_addrs(input string name, input int b_addr);
    if (addr_log.size() >= b_addr + NPIX) begin
      for (int i = 0; i < NPIX; i++) check({name, "_addr"}, addr_log[b_addr + i], BASE + i);
    end else begin
      check({name, "_addr_count"}, addr_log.size() - b_addr, NPIX);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_sr, b_log, b_wv, b_addr, b_rd, b_done, h_rd;
    logic [7:0] wv_pat;
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    #2;
    check("init_mem_rd_en", mem_rd_en, 0);
    check("init_mem_addr", mem_addr, BASE);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Plain pass.
    b_sr = n_sr; b_log = data_log.size(); b_wv = wv_log.size(); b_addr = addr_log.size();
    pulse_start();
    wait_done("basic_done");
    check("basic_done_latency", done_cyc - last_rd_cyc, 2);
    check_pixels("basic", b_sr, b_log);
    check_addrs("basic", b_addr);
    wv_pat = 8'hCC;
    if (wv_log.size() >= b_wv + NPIX) begin
      for (int i = 0; i < NPIX; i++) check("basic_window_valid", wv_log[b_wv + i], wv_pat[i]);
    end else begin
      check("basic_wv_count", wv_log.size() - b_wv, NPIX);
    end
    repeat (2) tick();
    check("idle_window_valid", window_valid, 0);
    check("idle_busy", busy, 0);

    // Hold for three cycles after the second read.
    b_sr = n_sr; b_log = data_log.size(); b_addr = addr_log.size(); b_rd = n_rd;
    pulse_start();
    wait_reads("hold_reach_2", b_rd, 2);
    tick();
    hold = 1'b1;
    h_rd = n_rd;
    repeat (3) tick();
    hold = 1'b0;
    check("hold_no_reads", n_rd - h_rd, 0);
    wait_done("hold_done");
    check_pixels("hold", b_sr, b_log);
    check_addrs("hold", b_addr);
    repeat (2) tick();

    // Start re-pulsed mid-pass is ignored.
    b_sr = n_sr; b_log = data_log.size(); b_rd = n_rd; b_done = n_done;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    wait_done("restart_done");
    repeat (6) tick();
    check("restart_single_done", n_done - b_done, 1);
    check("restart_rd_count", n_rd - b_rd, NPIX);
    check_pixels("restart", b_sr, b_log);

    // Reset after the fifth read aborts the pass.
    b_rd = n_rd; b_done = n_done;
    pulse_start();
    wait_reads("abort_reach_5", b_rd, 5);
    tick();
    check("abort_pre_sr_en", sr_en, 1);
    reset = 1'b1;
    #1;
    check("abort_mem_rd_en", mem_rd_en, 0);
    check("abort_mem_addr", mem_addr, BASE);
    check("abort_sr_en", sr_en, 0);
    check("abort_window_valid", window_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    tick();
    reset = 1'b0;
    b_rd = n_rd;
    repeat (6) tick();
    check("abort_no_done", n_done - b_done, 0);
    check("abort_no_reads", n_rd - b_rd, 0);
    b_sr = n_sr; b_log = data_log.size(); b_addr = addr_log.size();
    pulse_start();
    wait_done("fresh_done");
    if (addr_log.size() > b_addr) check("fresh_first_addr", addr_log[b_addr], BASE);
    else check("fresh_first_addr_seen", addr_log.size() - b_addr, 1);
    check_pixels("fresh", b_sr, b_log);

    // Back-to-back: start in the cycle right after done.
    tick();
    b_sr = n_sr; b_log = data_log.size(); b_addr = addr_log.size();
    pulse_start();
    wait_done("b2b_done");
    check_pixels("b2b", b_sr, b_log);
    check_addrs("b2b", b_addr);
    repeat (2) tick();

    // Random hold and start traffic against the model.
    for (int i = 0; i < 600; i++) begin
      hold  = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 9) == 0);
      tick();
    end
    hold  = 1'b0;
    start = 1'b0;
    repeat (30) tick();
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
